// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, bubble encoding and
// fetch FSM state encodings.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // presenting a request to the memory
        FETCH_WAIT = 2'd1,  // request accepted, response outstanding
        FETCH_HOLD = 2'd2,  // response parked in the hold buffer
        FETCH_DROP = 2'd3   // squashed request outstanding, discard its response
    } fetch_state_e;

    // The stall controls are driven together; any disagreement means "hold".
    function automatic logic fetch_consume(input logic pc_write, input logic if_id_write);
        return pc_write & if_id_write;
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry parking register for a fetched word that IF/ID could not accept.
module fetch_hold_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Capture on load; clear (flush or hand-off to IF/ID) wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage: owns the PC and the IF/ID register, issues one-outstanding
// fetches and reacts to load-use stalls and EX-stage branch flushes.
module fetch_stage_ctrl #(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_stall
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic            consume;
    logic            buf_load;
    logic            buf_clear;
    logic [31:0]     buf_data;
    logic            buf_valid;

    assign consume = fetch_consume(pc_write, if_id_write);

    fetch_hold_buffer #(
        .W (32)
    ) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (imem_rsp_data),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // FSM state, PC and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC & ALIGN_MASK;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Next state, PC update and IF/ID load/bubble/hold selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        if (flush) begin
            // Redirect beats everything: bubble IF/ID, drop any parked word.
            pc_d          = branch_target & ALIGN_MASK;
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            buf_clear     = 1'b1;
            case (state_q)
                // A response arriving this very cycle retires the outstanding request.
                FETCH_WAIT: state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
                FETCH_REQ:  state_d = imem_ready ? FETCH_DROP : FETCH_REQ;
                FETCH_HOLD: state_d = FETCH_REQ;
                FETCH_DROP: state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
                default:    state_d = FETCH_REQ;
            endcase
        end else begin
            // Whenever IF/ID is writable and nothing is delivered, it takes a bubble.
            if (if_id_write) begin
                if_id_pc_d    = pc_q;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
            case (state_q)
                FETCH_REQ: begin
                    if (imem_ready) begin
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (consume) begin
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = imem_rsp_data;
                            if_id_valid_d = 1'b1;
                            pc_d          = pc_q + PC_STEP;
                            state_d       = FETCH_REQ;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (consume && buf_valid) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = buf_data;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + PC_STEP;
                        buf_clear     = 1'b1;
                        state_d       = FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = FETCH_REQ;
                    end
                end
                default: state_d = FETCH_REQ;
            endcase
        end
    end

    // Request and stall indications are forced low while reset is asserted.
    assign imem_req    = rst_n && (state_q == FETCH_REQ);
    assign fetch_stall = rst_n && (state_q != FETCH_HOLD);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed, table-driven bench for fetch_stage_ctrl. Each table row is one
// clock cycle: inputs driven after the falling edge, outputs compared 1 ns later.
module tb_fetch_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A0  = 32'h1111_0000;
    localparam logic [31:0] A1  = 32'h1111_0004;
    localparam logic [31:0] A2  = 32'h2222_0008;
    localparam logic [31:0] A3  = 32'h3333_0100;
    localparam logic [31:0] A4  = 32'h4444_0200;
    localparam logic [31:0] A5  = 32'h5555_FFFC;
    localparam logic [31:0] A6  = 32'h6666_0040;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst_n;
        logic        pw;
        logic        iw;
        logic        fl;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    fetch_stage_ctrl #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_stall    (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] rst, input logic [31:0] pw, input logic [31:0] iw,
        input logic [31:0] fl, input logic [31:0] tgt, input logic [31:0] rdy,
        input logic [31:0] rv, input logic [31:0] rd, input logic [31:0] req,
        input logic [31:0] addr, input logic [31:0] stall, input logic [31:0] valid,
        input logic [31:0] pc, input logic [31:0] instr);
        vec_t v;
        v.rst_n   = rst[0];
        v.pw      = pw[0];
        v.iw      = iw[0];
        v.fl      = fl[0];
        v.tgt     = tgt;
        v.rdy     = rdy[0];
        v.rv      = rv[0];
        v.rd      = rd;
        v.e_req   = req[0];
        v.e_addr  = addr;
        v.e_stall = stall[0];
        v.e_valid = valid[0];
        v.e_pc    = pc;
        v.e_instr = instr;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input logic req, input logic [31:0] addr,
                                 input logic stall, input logic valid,
                                 input logic [31:0] pc, input logic [31:0] instr);
        check("imem_req",    row, {31'b0, imem_req},    {31'b0, req});
        check("imem_addr",   row, imem_addr,            addr);
        check("fetch_stall", row, {31'b0, fetch_stall}, {31'b0, stall});
        check("if_id_valid", row, {31'b0, if_id_valid}, {31'b0, valid});
        check("if_id_pc",    row, if_id_pc,             pc);
        check("if_id_instr", row, if_id_instr,          instr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        flush          = 1'b0;
        branch_target  = '0;
        imem_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        //               rst pw iw fl tgt           rdy rv rd    req addr          stl vld pc            instr
        // reset, then fetches at 0,4,8 with a 1-cycle memory
        vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0, 0,    0, 0,            0, 0, 0,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 0,            1, 0, 0,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A0,   0, 0,            1, 0, 0,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 4,            1, 1, 0,            A0));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A1,   0, 4,            1, 0, 4,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 8,            1, 1, 4,            A1));
        // three stalled cycles while the response arrives -> HOLD, then release
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 1, A2,   0, 8,            1, 0, 8,            NOP));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0, 0,    0, 8,            0, 0, 8,            NOP));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0, 0,    0, 8,            0, 0, 8,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0, 0,    0, 8,            0, 0, 8,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 12,           1, 1, 8,            A2));
        // flush to 0x103 while waiting; the next beat is discarded
        vecs.push_back(mk(1, 1, 1, 1, 32'h103,      0, 0, 0,    0, 12,           1, 0, 12,           NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, BAD,  0, 32'h100,      1, 0, 12,           NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 32'h100,      1, 0, 32'h100,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A3,   0, 32'h100,      1, 0, 32'h100,      NOP));
        // flush and stall in the same cycle: flush wins
        vecs.push_back(mk(1, 0, 0, 1, 32'h200,      0, 0, 0,    1, 32'h104,      1, 1, 32'h100,      A3));
        // memory not ready for four cycles: address held, bubbles into IF/ID
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0, 0,    1, 32'h200,      1, 0, 32'h104,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0, 0,    1, 32'h200,      1, 0, 32'h200,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0, 0,    1, 32'h200,      1, 0, 32'h200,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0, 0,    1, 32'h200,      1, 0, 32'h200,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 32'h200,      1, 0, 32'h200,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A4,   0, 32'h200,      1, 0, 32'h200,      NOP));
        // redirect to the top word, then PC wraps to zero
        vecs.push_back(mk(1, 1, 1, 1, 32'hFFFF_FFFE, 0, 0, 0,   1, 32'h204,      1, 1, 32'h200,      A4));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 32'hFFFF_FFFC, 1, 0, 32'h204,      NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A5,   0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 0,            1, 1, 32'hFFFF_FFFC, A5));
        // response and flush together in WAIT: response dropped, straight to REQ
        vecs.push_back(mk(1, 1, 1, 1, 32'h40,       0, 1, BAD,  0, 0,            1, 0, 0,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,    1, 32'h40,       1, 0, 0,            NOP));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 1, A6,   0, 32'h40,       1, 0, 32'h40,       NOP));
        // stalled request accepted; IF/ID keeps its valid word into WAIT
        vecs.push_back(mk(1, 0, 0, 0, 0,            1, 0, 0,    1, 32'h44,       1, 1, 32'h40,       A6));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0, 0,    0, 32'h44,       1, 1, 32'h40,       A6));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n          = vecs[i].rst_n;
            pc_write       = vecs[i].pw;
            if_id_write    = vecs[i].iw;
            flush          = vecs[i].fl;
            branch_target  = vecs[i].tgt;
            imem_ready     = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rd;
            #1;
            check_outputs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_stall,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
        end

        // Asynchronous reset in WAIT, asserted between clock edges.
        @(negedge clk);
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        imem_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NOP);

        // Release: FSM restarts in REQ at RESET_PC.
        @(negedge clk);
        rst_n       = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        #1;
        check_outputs(101, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
